// File: rtl/plot_box_sched_if.sv
// rtl/plot_box_sched_if.sv - Avalon slave and box stream signals of plot_box_sched
interface plot_box_sched_if #(
    parameter int CW = 10,
    parameter int LW = 3,
    parameter int AW = 14
);
    logic          chipselect;
    logic [3:0]    as_address;
    logic          as_write;
    logic [31:0]   as_writedata;
    logic          as_read;
    logic [31:0]   as_readdata;
    logic          frame_start;
    logic          box_valid;
    logic          box_ready;
    logic [CW-1:0] box_x0;
    logic [CW-1:0] box_y0;
    logic [CW-1:0] box_x1;
    logic [CW-1:0] box_y1;
    logic [LW-1:0] box_label;
    logic [AW-1:0] box_acc;
    logic          box_last;

    modport master (
        output chipselect, as_address, as_write, as_writedata, as_read, frame_start, box_ready,
        input  as_readdata, box_valid, box_x0, box_y0, box_x1, box_y1, box_label, box_acc, box_last
    );

    modport slave (
        input  chipselect, as_address, as_write, as_writedata, as_read, frame_start, box_ready,
        output as_readdata, box_valid, box_x0, box_y0, box_x1, box_y1, box_label, box_acc, box_last
    );
endinterface

// File: rtl/plot_box_sched.sv
// rtl/plot_box_sched.sv - double-buffered box-list scheduler, optional PLOT_CLAMP_EN push clamp
module plot_box_sched #(
    parameter int MAX_BOX = 16,
    parameter int CW      = 10,
    parameter int LW      = 3,
    parameter int AW      = 14,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input logic              clk,
    input logic              reset_n,
    plot_box_sched_if.slave  bus
);
    localparam int IW = $clog2(MAX_BOX);
    localparam int W  = IW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          load_en, orun_set;

    logic [W-1:0]  bcnt_q, acnt_q, acnt_eff, last_idx;
    logic          act_q, pending_q, ovf_q, orun_q;
    logic [31:0]   readdata_q;

    logic [CW-1:0] stg_x0_q, stg_y0_q, stg_x1_q, stg_y1_q;
    logic [LW-1:0] stg_lbl_q;
    logic [AW-1:0] stg_acc_q;
    logic [CW-1:0] px0, py0, px1, py1;

    logic [CW-1:0] mem_x0 [2][MAX_BOX];
    logic [CW-1:0] mem_y0 [2][MAX_BOX];
    logic [CW-1:0] mem_x1 [2][MAX_BOX];
    logic [CW-1:0] mem_y1 [2][MAX_BOX];
    logic [LW-1:0] mem_lbl [2][MAX_BOX];
    logic [AW-1:0] mem_acc [2][MAX_BOX];

    logic [CW-1:0] box_x0_q, box_y0_q, box_x1_q, box_y1_q;
    logic [LW-1:0] box_lbl_q;
    logic [AW-1:0] box_acc_q;

    logic wr, push, push_ok, commit, clr, swap;
    logic unused_wd;

    assign unused_wd = ^bus.as_writedata;
    assign wr        = bus.chipselect && bus.as_write;
    assign push      = wr && bus.as_address == 4'd1 && bus.as_writedata[0];
    assign commit    = wr && bus.as_address == 4'd0 && bus.as_writedata[0];
    assign clr       = wr && bus.as_address == 4'd10 && bus.as_writedata[0];
    assign push_ok   = push && !pending_q && bcnt_q != W'(MAX_BOX);
    assign swap      = bus.frame_start && pending_q;
    // a replay started by frame_start must already see the list it swaps in
    assign acnt_eff  = pending_q ? bcnt_q : acnt_q;
    assign last_idx  = acnt_q - W'(1);

    // box coordinates as they will be stored on push
    always_comb begin
`ifdef PLOT_CLAMP_EN
        logic [CW-1:0] cx0, cx1, cy0, cy1;
        cx0 = (stg_x0_q > CW'(H_RES - 1)) ? CW'(H_RES - 1) : stg_x0_q;
        cx1 = (stg_x1_q > CW'(H_RES - 1)) ? CW'(H_RES - 1) : stg_x1_q;
        cy0 = (stg_y0_q > CW'(V_RES - 1)) ? CW'(V_RES - 1) : stg_y0_q;
        cy1 = (stg_y1_q > CW'(V_RES - 1)) ? CW'(V_RES - 1) : stg_y1_q;
        px0 = (cx0 > cx1) ? cx1 : cx0;
        px1 = (cx0 > cx1) ? cx0 : cx1;
        py0 = (cy0 > cy1) ? cy1 : cy0;
        py1 = (cy0 > cy1) ? cy0 : cy1;
`else
        px0 = stg_x0_q;
        px1 = stg_x1_q;
        py0 = stg_y0_q;
        py1 = stg_y1_q;
`endif
    end

    // register file: staging, bank bookkeeping, sticky flags, registered reads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stg_x0_q <= '0; stg_y0_q <= '0; stg_x1_q <= '0; stg_y1_q <= '0;
            stg_lbl_q <= '0; stg_acc_q <= '0;
            bcnt_q <= '0; acnt_q <= '0; act_q <= 1'b0; pending_q <= 1'b0;
            ovf_q <= 1'b0; orun_q <= 1'b0; readdata_q <= '0;
        end else begin
            if (wr) begin
                case (bus.as_address)
                    4'd3: stg_x0_q  <= bus.as_writedata[CW-1:0];
                    4'd4: stg_y0_q  <= bus.as_writedata[CW-1:0];
                    4'd5: stg_x1_q  <= bus.as_writedata[CW-1:0];
                    4'd6: stg_y1_q  <= bus.as_writedata[CW-1:0];
                    4'd7: stg_lbl_q <= bus.as_writedata[LW-1:0];
                    4'd8: stg_acc_q <= bus.as_writedata[AW-1:0];
                    default: ;
                endcase
            end
            if (swap) begin
                act_q     <= ~act_q;
                acnt_q    <= bcnt_q;
                bcnt_q    <= '0;
                pending_q <= 1'b0;
            end
            // push is refused while pending, so it never races the swap above
            if (push_ok) bcnt_q <= bcnt_q + W'(1);
            if (push && !push_ok) ovf_q <= 1'b1;
            if (commit) pending_q <= 1'b1;
            if (clr) begin
                ovf_q  <= 1'b0;
                orun_q <= 1'b0;
            end
            if (orun_set) orun_q <= 1'b1;
            if (bus.chipselect && bus.as_read) begin
                case (bus.as_address)
                    4'd0:    readdata_q <= {27'b0, orun_q, ovf_q, pending_q, state_q};
                    4'd2:    readdata_q <= 32'(bcnt_q);
                    4'd9:    readdata_q <= 32'(acnt_q);
                    default: readdata_q <= '0;
                endcase
            end
        end
    end

    // back-bank write on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_x0[~act_q][bcnt_q[IW-1:0]]  <= px0;
            mem_y0[~act_q][bcnt_q[IW-1:0]]  <= py0;
            mem_x1[~act_q][bcnt_q[IW-1:0]]  <= px1;
            mem_y1[~act_q][bcnt_q[IW-1:0]]  <= py1;
            mem_lbl[~act_q][bcnt_q[IW-1:0]] <= stg_lbl_q;
            mem_acc[~act_q][bcnt_q[IW-1:0]] <= stg_acc_q;
        end
    end

    // replay FSM next state; an accept in WAIT loads the next entry directly
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        load_en  = 1'b0;
        orun_set = 1'b0;
        if (bus.frame_start && state_q != S_IDLE) begin
            orun_set = 1'b1;
            valid_d  = 1'b0;
            idx_d    = '0;
            state_d  = (acnt_eff != '0) ? S_ISSUE : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.frame_start && acnt_eff != '0) begin
                        idx_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    load_en = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.box_ready) begin
                        if (idx_q == last_idx) begin
                            valid_d = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + W'(1);
                            load_en = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // replay state and box output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE; idx_q <= '0; valid_q <= 1'b0;
            box_x0_q <= '0; box_y0_q <= '0; box_x1_q <= '0; box_y1_q <= '0;
            box_lbl_q <= '0; box_acc_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            if (load_en) begin
                box_x0_q  <= mem_x0[act_q][idx_d[IW-1:0]];
                box_y0_q  <= mem_y0[act_q][idx_d[IW-1:0]];
                box_x1_q  <= mem_x1[act_q][idx_d[IW-1:0]];
                box_y1_q  <= mem_y1[act_q][idx_d[IW-1:0]];
                box_lbl_q <= mem_lbl[act_q][idx_d[IW-1:0]];
                box_acc_q <= mem_acc[act_q][idx_d[IW-1:0]];
            end
        end
    end

    assign bus.as_readdata = readdata_q;
    assign bus.box_valid   = valid_q;
    assign bus.box_x0      = box_x0_q;
    assign bus.box_y0      = box_y0_q;
    assign bus.box_x1      = box_x1_q;
    assign bus.box_y1      = box_y1_q;
    assign bus.box_label   = box_lbl_q;
    assign bus.box_acc     = box_acc_q;
    assign bus.box_last    = valid_q && idx_q == last_idx;
endmodule

// File: tb/tb_plot_box_sched.sv
// tb/tb_plot_box_sched.sv - randomized self-checking bench for plot_box_sched
module tb_plot_box_sched;
    localparam int MAX_BOX = 16;

    typedef struct packed {
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  y1;
        logic [2:0]  lbl;
        logic [13:0] acc;
    } box_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    box_t back_m[$];
    box_t act_m[$];
    bit   pending_m = 0;
    bit   ovf_m = 0;
    bit   orun_m = 0;

    plot_box_sched_if #(.CW(10), .LW(3), .AW(14)) bus ();

    plot_box_sched #(.MAX_BOX(MAX_BOX), .CW(10), .LW(3), .AW(14), .H_RES(640), .V_RES(480)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic box_t stored(input box_t b);
        box_t r;
        r = b;
`ifdef PLOT_CLAMP_EN
        if (r.x0 > 10'd639) r.x0 = 10'd639;
        if (r.x1 > 10'd639) r.x1 = 10'd639;
        if (r.y0 > 10'd479) r.y0 = 10'd479;
        if (r.y1 > 10'd479) r.y1 = 10'd479;
        if (r.x0 > r.x1) r = '{x0: r.x1, y0: r.y0, x1: r.x0, y1: r.y1, lbl: r.lbl, acc: r.acc};
        if (r.y0 > r.y1) r = '{x0: r.x0, y0: r.y1, x1: r.x1, y1: r.y0, lbl: r.lbl, acc: r.acc};
`endif
        return r;
    endfunction

    function automatic box_t rand_box();
        box_t b;
        b.x0 = 10'($urandom_range(0, 1023));
        b.y0 = 10'($urandom_range(0, 1023));
        b.x1 = 10'($urandom_range(0, 1023));
        b.y1 = 10'($urandom_range(0, 1023));
        b.lbl = 3'($urandom_range(0, 7));
        b.acc = 14'($urandom_range(0, 16383));
        return b;
    endfunction

    task automatic av_write(input logic [3:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.as_write = 1'b1; bus.as_address = a; bus.as_writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.as_write = 1'b0;
    endtask

    task automatic av_read(input logic [3:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.as_read = 1'b1; bus.as_address = a;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.as_read = 1'b0;
        d = bus.as_readdata;
    endtask

    task automatic push_box(input box_t b);
        av_write(4'd3, 32'(b.x0));
        av_write(4'd4, 32'(b.y0));
        av_write(4'd5, 32'(b.x1));
        av_write(4'd6, 32'(b.y1));
        av_write(4'd7, 32'(b.lbl));
        av_write(4'd8, 32'(b.acc));
        av_write(4'd1, 32'h1);
        if (pending_m || back_m.size() == MAX_BOX) ovf_m = 1;
        else back_m.push_back(stored(b));
    endtask

    task automatic commit();
        av_write(4'd0, 32'h1);
        pending_m = 1;
    endtask

    task automatic frame();
        if (pending_m) begin
            act_m = back_m;
            back_m.delete();
            pending_m = 0;
        end
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        av_read(4'd0, d);
        n_cmp++;
        if (d !== {27'b0, orun_m, ovf_m, pending_m, 2'b00}) begin
            n_bad++; $display("FAIL %s status: got %h want %h", tag, d, {27'b0, orun_m, ovf_m, pending_m, 2'b00});
        end
        av_read(4'd2, d);
        n_cmp++;
        if (d !== 32'(back_m.size())) begin
            n_bad++; $display("FAIL %s bcnt: got %0d want %0d", tag, d, back_m.size());
        end
        av_read(4'd9, d);
        n_cmp++;
        if (d !== 32'(act_m.size())) begin
            n_bad++; $display("FAIL %s acnt: got %0d want %0d", tag, d, act_m.size());
        end
    endtask

    task automatic collect(input int stall_n, input bit rnd, input string tag);
        box_t cur, prev;
        bit   prev_stall, rdy;
        int   got, cyc, n;
        n = act_m.size(); got = 0; cyc = 0; prev_stall = 0; prev = '0;
        while (got < n && cyc < 400) begin
            cur = {bus.box_x0, bus.box_y0, bus.box_x1, bus.box_y1, bus.box_label, bus.box_acc};
            if (cyc < stall_n) rdy = 0;
            else if (rnd) rdy = ($urandom_range(0, 2) != 0);
            else rdy = 1;
            bus.box_ready = rdy;
            if (bus.box_valid) begin
                if (prev_stall) begin
                    n_cmp++;
                    if (cur !== prev) begin
                        n_bad++; $display("FAIL %s stall_hold: got %h want %h", tag, cur, prev);
                    end
                end
                n_cmp++;
                if (bus.box_last !== (got == n - 1)) begin
                    n_bad++; $display("FAIL %s box_last idx %0d: got %b want %b", tag, got, bus.box_last, got == n - 1);
                end
                if (rdy) begin
                    n_cmp++;
                    if (cur !== act_m[got]) begin
                        n_bad++; $display("FAIL %s box %0d: got %h want %h", tag, got, cur, act_m[got]);
                    end
                    got++;
                end
                prev_stall = !rdy;
                prev = cur;
            end else begin
                prev_stall = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.box_ready = 1'b0;
        n_cmp++;
        if (got != n) begin
            n_bad++; $display("FAIL %s count: got %0d boxes want %0d", tag, got, n);
        end
        n_cmp++;
        if (bus.box_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s valid_after: got %b want 0", tag, bus.box_valid);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.box_valid, bus.box_last, bus.box_x0, bus.box_y0, bus.box_x1, bus.box_y1, bus.box_label, bus.box_acc, bus.as_readdata} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got nonzero valid=%b x0=%0d rd=%h want 0", bus.box_valid, bus.box_x0, bus.as_readdata);
        end
        check_regs("reset");
        av_write(4'd1, 32'h2);
        check_regs("push_bit0_clear");
    endtask

    task automatic test_single();
        box_t b;
        b = '{x0: 10'd10, y0: 10'd20, x1: 10'd100, y1: 10'd200, lbl: 3'd3, acc: 14'd5000};
        push_box(b);
        commit();
        check_regs("single_committed");
        frame();
        n_cmp++;
        if (bus.box_valid !== 1'b0) begin
            n_bad++; $display("FAIL latency_early: got %b want 0", bus.box_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.box_valid !== 1'b1) begin
            n_bad++; $display("FAIL latency_2cyc: got %b want 1", bus.box_valid);
        end
        collect(0, 0, "single");
        check_regs("single_done");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) push_box(rand_box());
        commit();
        frame();
        collect(7, 0, "stall");
        check_regs("stall_done");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < MAX_BOX + 1; i++) push_box(rand_box());
        check_regs("overflow");
        av_write(4'd10, 32'h1);
        ovf_m = 0; orun_m = 0;
        check_regs("ovf_clear");
    endtask

    task automatic test_push_pending();
        commit();
        push_box(rand_box());
        check_regs("push_while_pending");
        frame();
        collect(0, 1, "full_bank");
        check_regs("after_swap");
        av_write(4'd10, 32'h1);
        ovf_m = 0;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 4; i++) push_box(rand_box());
        commit();
        frame();
        bus.box_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++;
        if (bus.box_valid !== 1'b1) begin
            n_bad++; $display("FAIL overrun_stalled_valid: got %b want 1", bus.box_valid);
        end
        frame();
        orun_m = 1;
        collect(0, 1, "overrun_restart");
        check_regs("overrun");
        av_write(4'd10, 32'h1);
        orun_m = 0;
        check_regs("orun_clear");
    endtask

    task automatic test_clamp();
        box_t b;
        b = '{x0: 10'd700, y0: 10'd600, x1: 10'd5, y1: 10'd2, lbl: 3'd1, acc: 14'd77};
        push_box(b);
        commit();
        frame();
        @(posedge clk); #1;
        n_cmp++;
`ifdef PLOT_CLAMP_EN
        if (bus.box_x0 !== 10'd5 || bus.box_x1 !== 10'd639) begin
            n_bad++; $display("FAIL clamp_x: got %0d/%0d want 5/639", bus.box_x0, bus.box_x1);
        end
`else
        if (bus.box_x0 !== 10'd700 || bus.box_x1 !== 10'd5) begin
            n_bad++; $display("FAIL verbatim_x: got %0d/%0d want 700/5", bus.box_x0, bus.box_x1);
        end
`endif
        collect(0, 0, "clamp");
    endtask

    task automatic test_random_frames();
        int k;
        for (int f = 0; f < 8; f++) begin
            k = (f == 2) ? 0 : $urandom_range(1, MAX_BOX);
            for (int i = 0; i < k; i++) push_box(rand_box());
            if (f != 5) commit();
            frame();
            if (act_m.size() == 0) begin
                repeat (5) begin @(posedge clk); #1; end
                n_cmp++;
                if (bus.box_valid !== 1'b0) begin
                    n_bad++; $display("FAIL empty_list_valid: got %b want 0", bus.box_valid);
                end
            end
            collect($urandom_range(0, 4), 1, "random");
            check_regs("random");
            if (ovf_m) begin
                av_write(4'd10, 32'h1);
                ovf_m = 0;
            end
        end
    endtask

    initial begin
        bus.chipselect = 1'b0; bus.as_address = '0; bus.as_write = 1'b0; bus.as_writedata = '0;
        bus.as_read = 1'b0; bus.frame_start = 1'b0; bus.box_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_push_pending();
        test_overrun();
        test_clamp();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
